// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the main-memory access controller.
package mem_ctrl_pkg;

    localparam int DEFAULT_AW = 12;
    localparam int DEFAULT_DW = 16;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters.
// MEM_ARB_RR_EN adds a last-served pointer for round-robin ties; otherwise data beats fetch.
module mem_arb_pick
    import mem_ctrl_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
`endif
    input  logic f_req,
    input  logic d_req,
    output logic win
);

`ifdef MEM_ARB_RR_EN
    logic last_q;
    logic last_d;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        win    = REQ_DATA;
        if (f_req && d_req) begin
            win = ~last_q;
        end else if (f_req) begin
            win = REQ_FETCH;
        end
        last_d = grant_en ? win : last_q;
    end

    // Reset to "data served last" so the first tie after reset goes to fetch.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            last_q <= REQ_DATA;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        win = (f_req && !d_req) ? REQ_FETCH : REQ_DATA;
    end
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Two-port sequencer for the edge-strobed main memory: one clean strobe edge per access.
// Optional round-robin tie-break via MEM_ARB_RR_EN (default build: data beats fetch).
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AW            = DEFAULT_AW,
    parameter int DW            = DEFAULT_DW,
    parameter int STROBE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_i,
    output logic [DW-1:0] mem_memin,
    input  logic [DW-1:0] mem_memout
);

    mem_state_t    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] mem_i_q, mem_i_d;
    logic [DW-1:0] mem_memin_q, mem_memin_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
    logic          f_done_q, f_done_d, d_done_q, d_done_d;
    logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic          win;
    logic          grant_en;

    assign grant_en = (state_q == IDLE) && (f_req || d_req);

    mem_arb_pick u_arb (
`ifdef MEM_ARB_RR_EN
        .clk      (clk),
        .reset    (reset),
        .grant_en (grant_en),
`endif
        .f_req    (f_req),
        .d_req    (d_req),
        .win      (win)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_i_d     = mem_i_q;
        mem_memin_d = mem_memin_q;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        f_gnt_d     = f_gnt_q;
        d_gnt_d     = d_gnt_q;
        f_done_d    = f_done_q;
        d_done_d    = d_done_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;

        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    state_d     = STROBE;
                    cnt_d       = 3'd1;
                    owner_d     = win;
                    we_d        = (win == REQ_DATA) && d_we;
                    mem_i_d     = (win == REQ_DATA) ? d_addr : f_addr;
                    if (we_d) begin
                        mem_memin_d = d_wdata;
                    end
                    f_gnt_d     = (win == REQ_FETCH);
                    d_gnt_d     = (win == REQ_DATA);
                    mem_read_d  = !we_d;
                    mem_write_d = we_d;
                end
            end
            STROBE: begin
                if (cnt_q == 3'(STROBE_CYCLES)) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    f_done_d    = (owner_q == REQ_FETCH);
                    d_done_d    = (owner_q == REQ_DATA);
                    // Memory output settled during the strobe; capture it for reads only.
                    if (!we_q) begin
                        if (owner_q == REQ_DATA) begin
                            d_rdata_d = mem_memout;
                        end else begin
                            f_rdata_d = mem_memout;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                f_gnt_d  = 1'b0;
                d_gnt_d  = 1'b0;
                f_done_d = 1'b0;
                d_done_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            owner_q     <= REQ_FETCH;
            we_q        <= 1'b0;
            mem_i_q     <= '0;
            mem_memin_q <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            f_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            f_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_i_q     <= mem_i_d;
            mem_memin_q <= mem_memin_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            f_gnt_q     <= f_gnt_d;
            d_gnt_q     <= d_gnt_d;
            f_done_q    <= f_done_d;
            d_done_q    <= d_done_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign f_gnt     = f_gnt_q;
    assign f_done    = f_done_q;
    assign f_rdata   = f_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_i     = mem_i_q;
    assign mem_memin = mem_memin_q;

endmodule
